// File: rtl/score_disp_scan.sv
// Time-multiplexed 4-digit "AA.BB" scanner with per-frame input snapshot and winner blink.
// Optional define LEADING_ZERO_BLANK_EN blanks tens digits that are zero.
module score_disp_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [1:0] player,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CntMax   = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BlinkMax = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sa_q, sa_d, sb_q, sb_d;
  logic [1:0]    sp_q, sp_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick, frame;
  logic [3:0]    val, ones, digit;
  logic          tens, blank;
  logic [7:0]    lut;

  always_comb begin
    tick    = (cnt_q == CntMax);
    frame   = tick && (idx_q == 2'd3);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    sa_d    = frame ? A : sa_q;
    sb_d    = frame ? B : sb_q;
    sp_d    = frame ? player : sp_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (frame) begin
      // Loading 00 clears blink at once; counting uses the outgoing snapshot.
      if (player == 2'b00) begin
        blink_d = '0;
        phase_d = 1'b0;
      end else if (sp_q != 2'b00) begin
        if (blink_q == BlinkMax) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    val   = idx_q[1] ? sa_q : sb_q;
    tens  = (val >= 4'd10);
    ones  = tens ? val - 4'd10 : val;
    digit = idx_q[0] ? {3'b000, tens} : ones;
    unique case (digit)
      4'd0:    lut = 8'hC0;
      4'd1:    lut = 8'hF9;
      4'd2:    lut = 8'hA4;
      4'd3:    lut = 8'hB0;
      4'd4:    lut = 8'h99;
      4'd5:    lut = 8'h92;
      4'd6:    lut = 8'h82;
      4'd7:    lut = 8'hF8;
      4'd8:    lut = 8'h80;
      4'd9:    lut = 8'h90;
      default: lut = 8'hFF;
    endcase
    blank = phase_q && ((sp_q == 2'b11) ||
                        (sp_q == 2'b01 && idx_q[1]) ||
                        (sp_q == 2'b10 && !idx_q[1]));
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q[0] && !tens) blank = 1'b1;
`else
`endif
    an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = blank ? 8'hFF : {(idx_q != 2'd2), lut[6:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      sa_q    <= 4'd0;
      sb_q    <= 4'd0;
      sp_q    <= 2'b00;
      blink_q <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sp_q    <= sp_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_score_disp_scan.sv
// Directed scoreboard bench for score_disp_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// Expected digits are pushed per frame and popped at the first cycle each digit is lit.
module tb_score_disp_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic [1:0] player;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  score_disp_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .player(player), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Push idx0..idx3 expectations for one frame showing a/b with result p and blink phase ph.
  task automatic push_frame(input int a, input int b, input int p, input int ph);
    for (int i = 0; i < 4; i++) begin
      int v, d;
      bit tn, blank;
      logic [3:0] an_e;
      logic [7:0] seg_e;
      v  = (i >= 2) ? a : b;
      tn = (v >= 10);
      d  = (i % 2 == 1) ? int'(tn) : (tn ? v - 10 : v);
      blank = (ph == 1) && (p == 3 || (p == 1 && i >= 2) || (p == 2 && i < 2));
`ifdef LEADING_ZERO_BLANK_EN
      if (i % 2 == 1 && !tn) blank = 1'b1;
`endif
      an_e  = 4'hF ^ (4'b0001 << i);
      seg_e = enc(d) & ((i == 2) ? 8'h7F : 8'hFF);
      exp_q.push_back(blank ? 12'hFFF : {an_e, seg_e});
    end
  endtask

  task automatic check_now(input string tag);
    logic [11:0] e;
    logic [11:0] obs;
    obs = {an, seg};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, an/seg got %h/%h", tag, an, seg);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: an/seg got %b/%h expected %b/%h", tag, obs[11:8], obs[7:0],
               e[11:8], e[7:0]);
      end
    end
  endtask

  task automatic check_digit(input string tag);
    check_now(tag);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < 4; i++) check_digit($sformatf("%s_d%0d", tag, i));
  endtask

  initial begin
    rst = 1'b1; A = 4'd0; B = 4'd0; player = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(12'hFFF);
    check_now("reset_hold");
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // F0: snapshot still zero while new inputs arrive mid-frame.
    push_frame(0, 0, 0, 0);
    check_digit("f0_d0");
    A = 4'd7; B = 4'd12; player = 2'b00;
    for (int i = 1; i < 4; i++) check_digit($sformatf("f0_d%0d", i));

    push_frame(7, 12, 0, 0);
    check_digit("f1_d0");
    A = 4'd15; B = 4'd10;
    for (int i = 1; i < 4; i++) check_digit($sformatf("f1_d%0d", i));

    push_frame(15, 10, 0, 0);
    check_digit("f2_d0");
    A = 4'd3; B = 4'd1; player = 2'b01;
    for (int i = 1; i < 4; i++) check_digit($sformatf("f2_d%0d", i));

    // A wins: two lit frames, two blanked, repeating.
    push_frame(3, 1, 1, 0); check_frame("f3");
    push_frame(3, 1, 1, 0); check_frame("f4");
    push_frame(3, 1, 1, 1); check_frame("f5");
    push_frame(3, 1, 1, 1); check_frame("f6");
    push_frame(3, 1, 1, 0); check_frame("f7");
    push_frame(3, 1, 1, 0); check_frame("f8");
    push_frame(3, 1, 1, 1);
    check_digit("f9_d0");
    player = 2'b00;
    for (int i = 1; i < 4; i++) check_digit($sformatf("f9_d%0d", i));

    // Back to in-play from phase 1: visible immediately.
    push_frame(3, 1, 0, 0);
    check_digit("f10_d0");
    player = 2'b11;
    for (int i = 1; i < 4; i++) check_digit($sformatf("f10_d%0d", i));

    push_frame(3, 1, 3, 0); check_frame("f11");
    push_frame(3, 1, 3, 0); check_frame("f12");
    push_frame(3, 1, 3, 1);
    check_digit("f13_d0");
    check_digit("f13_d1");
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());

    // Reset during idx2 of a draw-blank frame.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(12'hFFF);
    check_now("midscan_reset");
    rst = 1'b0; A = 4'd0; B = 4'd0; player = 2'b00;
    @(posedge clk);
    @(negedge clk);

    push_frame(0, 0, 0, 0);
    check_digit("post_rst_d0");
    A = 4'd5; B = 4'd9;
    for (int i = 1; i < 4; i++) check_digit($sformatf("post_rst_d%0d", i));

    push_frame(5, 9, 0, 0); check_frame("lzb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
